frame_compare_tracker: RTL

- Accepts a stream of unsigned 4-bit samples over a valid/ready handshake.
- Groups samples into fixed-length frames and tracks each frame's running maximum and minimum.
- At frame end, classifies the frame maximum against a threshold with one-hot less/equal/greater flags.
- Sits directly downstream of the 4-bit magnitude comparator stage. It consumes the same a-vs-b less/equal/greater semantics, applied sequentially across a frame, and hands a registered frame summary to the next stage.

---
 rtl/frame_compare_tracker.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/frame_compare_tracker.sv
// frame_compare_tracker
//
// Purpose:
//   Consumes unsigned WIDTH-bit samples over a valid/ready handshake, groups
//   them into frames of FRAME_LEN samples, tracks the running maximum and
//   minimum of each frame and, at frame end, presents a registered summary:
//   frame max/min plus one-hot less/equal/greater flags of the frame max
//   against the threshold captured on the frame's first beat.
//
// Optional feature (macro THRESH_CNT_EN):
//   When defined, per-sample less/equal/greater counts against the captured
//   threshold are accumulated and published with the summary. When not
//   defined, the count ports and all counter logic are absent.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   i_in_valid    in   sample present
//   o_in_ready    out  block can accept a sample (ACCUM state)
//   i_in_data     in   sample value (WIDTH)
//   i_thresh      in   threshold, captured on the first beat of each frame
//   o_out_valid   out  frame summary present (REPORT state)
//   i_out_ready   in   consumer accepts summary
//   o_out_max     out  largest sample of the frame
//   o_out_min     out  smallest sample of the frame
//   o_out_l/e/g   out  frame max <, ==, > captured threshold (one-hot)
//   o_out_cnt_lt/eq/gt  out  per-sample classification counts (THRESH_CNT_EN)

module frame_compare_tracker #(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic [WIDTH-1:0] i_thresh,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_max,
  output logic [WIDTH-1:0] o_out_min,
  output logic             o_out_l,
  output logic             o_out_e,
  output logic             o_out_g
`ifdef THRESH_CNT_EN
  ,
  output logic [CNT_W-1:0] o_out_cnt_lt,
  output logic [CNT_W-1:0] o_out_cnt_eq,
  output logic [CNT_W-1:0] o_out_cnt_gt
`endif
);

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [WIDTH-1:0] r_run_max;
  logic [WIDTH-1:0] r_run_min;
  logic [WIDTH-1:0] r_thr_q;

  logic             w_beat;
  logic             w_first;
  logic             w_last;
  logic [WIDTH-1:0] w_thr;
  logic [WIDTH-1:0] w_max;
  logic [WIDTH-1:0] w_min;

  assign o_in_ready  = (r_state == ACCUM);
  assign o_out_valid = (r_state == REPORT);

  assign w_beat  = i_in_valid && (r_state == ACCUM);
  assign w_first = (r_beat_cnt == '0);
  assign w_last  = (r_beat_cnt == LAST_IDX);

  // The first beat of a frame sees the live threshold; later beats use the
  // captured copy so mid-frame threshold changes are ignored.
  assign w_thr = w_first ? i_thresh : r_thr_q;

  // Updated extremes including the current beat; the first beat seeds both.
  // Strict comparisons keep the stored value on ties.
  assign w_max = (w_first || (i_in_data > r_run_max)) ? i_in_data : r_run_max;
  assign w_min = (w_first || (i_in_data < r_run_min)) ? i_in_data : r_run_min;

`ifdef THRESH_CNT_EN
  logic [CNT_W-1:0] r_cnt_lt;
  logic [CNT_W-1:0] r_cnt_eq;
  logic [CNT_W-1:0] r_cnt_gt;
  logic [CNT_W-1:0] w_cnt_lt;
  logic [CNT_W-1:0] w_cnt_eq;
  logic [CNT_W-1:0] w_cnt_gt;

  // Counters restart from zero on the first beat instead of needing a
  // separate clear cycle, so back-to-back frames lose no throughput.
  assign w_cnt_lt = (w_first ? '0 : r_cnt_lt) + CNT_W'(i_in_data <  w_thr);
  assign w_cnt_eq = (w_first ? '0 : r_cnt_eq) + CNT_W'(i_in_data == w_thr);
  assign w_cnt_gt = (w_first ? '0 : r_cnt_gt) + CNT_W'(i_in_data >  w_thr);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ACCUM;
      r_beat_cnt <= '0;
      r_run_max  <= '0;
      r_run_min  <= '0;
      r_thr_q    <= '0;
      o_out_max  <= '0;
      o_out_min  <= '0;
      o_out_l    <= 1'b0;
      o_out_e    <= 1'b0;
      o_out_g    <= 1'b0;
`ifdef THRESH_CNT_EN
      r_cnt_lt     <= '0;
      r_cnt_eq     <= '0;
      r_cnt_gt     <= '0;
      o_out_cnt_lt <= '0;
      o_out_cnt_eq <= '0;
      o_out_cnt_gt <= '0;
`endif
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_beat) begin
            r_run_max <= w_max;
            r_run_min <= w_min;
            if (w_first) begin
              r_thr_q <= i_thresh;
            end
`ifdef THRESH_CNT_EN
            r_cnt_lt <= w_cnt_lt;
            r_cnt_eq <= w_cnt_eq;
            r_cnt_gt <= w_cnt_gt;
`endif
            if (w_last) begin
              r_beat_cnt <= '0;
              o_out_max  <= w_max;
              o_out_min  <= w_min;
              o_out_l    <= (w_max <  w_thr);
              o_out_e    <= (w_max == w_thr);
              o_out_g    <= (w_max >  w_thr);
`ifdef THRESH_CNT_EN
              o_out_cnt_lt <= w_cnt_lt;
              o_out_cnt_eq <= w_cnt_eq;
              o_out_cnt_gt <= w_cnt_gt;
`endif
              r_state    <= REPORT;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        REPORT: begin
          if (i_out_ready) begin
            r_state <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule
